// File: rtl/commit_trace_serializer_pkg.sv
// Shared trace-stream definitions: word tags, serializer FSM states and the commit record layout.
// Sinks that decode the stream import this package so that they use the same tag values.
package commit_trace_serializer_pkg;

  typedef enum logic [1:0] {
    TRACE_TAG_PC    = 2'd0,
    TRACE_TAG_INSTR = 2'd1,
    TRACE_TAG_WB    = 2'd2
  } trace_tag_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND_PC,
    ST_SEND_INSTR,
    ST_SEND_WB
  } trace_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } commit_rec_t;

  localparam int unsigned REC_W = $bits(commit_rec_t);

endpackage

// File: rtl/commit_trace_serializer_fifo.sv
// Synchronous FIFO for commit records. full/empty come from the registered count,
// so they reflect the occupancy before any same-cycle push or pop.
module trace_fifo #(
  parameter int unsigned WIDTH  = 102,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [ADDR_W:0]   count_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_q, rd_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + ADDR_W'(1);
      if (do_pop)  rd_q <= rd_q + ADDR_W'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/commit_trace_serializer.sv
// Captures one commit record per cycle into a FIFO and serialises each record into
// tagged 32-bit words (PC, INSTR, optional WB) on a registered valid/ready stream.
module commit_trace_serializer #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned DROP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              commit_valid,
  input  logic [31:0]       commit_pc,
  input  logic [31:0]       commit_instr,
  input  logic              commit_wen,
  input  logic [4:0]        commit_waddr,
  input  logic [31:0]       commit_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_tag,
  output logic [31:0]       out_data,
  output logic              overflow,
  output logic [DROP_W-1:0] drop_cnt
);

  import commit_trace_serializer_pkg::*;

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned CW    = ADDR_W + 1;

  commit_rec_t       rec_in, rec_head, hold_q, hold_d;
  logic              fifo_full, fifo_empty, pop, drop;
  logic [ADDR_W:0]   fifo_count;
  trace_state_e      state_q, state_d;
  logic              valid_q, valid_d;
  trace_tag_e        tag_q, tag_d;
  logic [31:0]       data_q, data_d;
  logic              ovf_q;
  logic [DROP_W-1:0] drop_q;
  logic              load, finish;
  logic              unused_waddr;

  assign rec_in = {commit_pc, commit_instr, commit_wen, commit_waddr, commit_wdata};
  assign drop   = commit_valid & fifo_full;

  trace_fifo #(
    .WIDTH  (REC_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (commit_valid),
    .pop_i   (pop),
    .wdata_i (rec_in),
    .rdata_o (rec_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // waddr travels with the record but is not emitted; sinks read rd from the INSTR word.
  assign unused_waddr = ^hold_q.waddr;

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    pop     = 1'b0;
    load    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE:    load = ~fifo_empty;
      ST_SEND_PC: if (out_ready) begin
        tag_d   = TRACE_TAG_INSTR;
        data_d  = hold_q.instr;
        state_d = ST_SEND_INSTR;
      end
      ST_SEND_INSTR: if (out_ready) begin
        if (hold_q.wen) begin
          tag_d   = TRACE_TAG_WB;
          data_d  = hold_q.wdata;
          state_d = ST_SEND_WB;
        end else begin
          finish = 1'b1;
        end
      end
      ST_SEND_WB: if (out_ready) finish = 1'b1;
      default:    state_d = ST_IDLE;
    endcase
    // End of a record: chain straight into the next one to avoid a bubble.
    if (finish) begin
      if (!fifo_empty) begin
        load = 1'b1;
      end else begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    end
    if (load) begin
      pop     = 1'b1;
      hold_d  = rec_head;
      valid_d = 1'b1;
      tag_d   = TRACE_TAG_PC;
      data_d  = rec_head.pc;
      state_d = ST_SEND_PC;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      hold_q  <= '0;
      valid_q <= 1'b0;
      tag_q   <= TRACE_TAG_PC;
      data_q  <= '0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (fifo_count <= CW'(DEPTH));
  end

  assign out_valid = valid_q;
  assign out_tag   = tag_q;
  assign out_data  = data_q;
  assign overflow  = ovf_q;
  assign drop_cnt  = drop_q;

endmodule
